// File: rtl/card_pkg.sv
// Shared card word layout, state encodings and controller FSM states for the
// card game logic.
package card_pkg;

  localparam int CARD_W   = 14;
  localparam int COLOUR_W = 12;
  localparam int ADDR_W   = 4;

  localparam logic [1:0] CARD_INACTIVE  = 2'b00;
  localparam logic [1:0] CARD_FACE_UP   = 2'b01;
  localparam logic [1:0] CARD_FACE_DOWN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK1,
    ST_WAIT2,
    ST_CHK2,
    ST_HOLD,
    ST_RES_A,
    ST_RES_B,
    ST_DONE
  } ctrl_state_t;

  function automatic logic [CARD_W-1:0] card_word(input logic [COLOUR_W-1:0] colour,
                                                  input logic [1:0]          st);
    return {colour, st};
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Display-hold timer: a start pulse arms it, o_expired is high for exactly one
// cycle, HOLD_CYCLES cycles after the start pulse was sampled.
module hold_timer #(
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_expired
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == LAST) r_run <= 1'b0;
      else               r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = r_run && (r_cnt == LAST);

endmodule

// File: rtl/card_match_ctrl.sv
// Card-matching game controller: flips selected cards, holds a pair face-up,
// resolves it and tracks found pairs. Optional miss counter: CARD_MISS_COUNT_EN.
module card_match_ctrl
  import card_pkg::*;
#(
  parameter int N_CARDS     = 16,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_valid,
  input  logic [ADDR_W-1:0] sel_index,
  output logic              sel_ready,
  output logic              sel_reject,
  output logic              rf_w_enable,
  output logic [ADDR_W-1:0] rf_w_address,
  output logic [CARD_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r_address,
  input  logic [CARD_W-1:0] rf_r_data,
  output logic              pair_found,
  output logic              pair_miss,
  output logic [ADDR_W-1:0] pairs_matched,
  output logic              game_done
`ifdef CARD_MISS_COUNT_EN
  ,
  output logic [7:0]        miss_count
`endif
);

  localparam logic [ADDR_W:0]   LIM       = (ADDR_W + 1)'(N_CARDS);
  localparam logic [ADDR_W-1:0] ALL_PAIRS = ADDR_W'(N_CARDS / 2);

  ctrl_state_t         r_state;
  logic [ADDR_W-1:0]   r_idx_a;
  logic [ADDR_W-1:0]   r_idx_b;
  logic [COLOUR_W-1:0] r_col_a;
  logic [COLOUR_W-1:0] r_col_b;

  logic                w_accept;
  logic [1:0]          w_rd_state;
  logic [COLOUR_W-1:0] w_rd_colour;
  logic                w_in_range;
  logic                w_legal1;
  logic                w_legal2;
  logic                w_colour_eq;
  logic [1:0]          w_res_state;
  logic                w_tmr_start;
  logic                w_expired;

  // rf_r_address doubles as the latched index of the card under check.
  assign w_accept    = sel_valid && sel_ready;
  assign w_rd_state  = rf_r_data[1:0];
  assign w_rd_colour = rf_r_data[CARD_W-1:2];
  assign w_in_range  = {1'b0, rf_r_address} < LIM;
  assign w_legal1    = w_in_range && (w_rd_state == CARD_FACE_DOWN);
  assign w_legal2    = w_legal1 && (rf_r_address != r_idx_a);
  assign w_colour_eq = (r_col_a == r_col_b);
  assign w_res_state = w_colour_eq ? CARD_INACTIVE : CARD_FACE_DOWN;
  assign w_tmr_start = (r_state == ST_CHK2) && w_legal2;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_tmr_start),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_idx_a       <= '0;
      r_idx_b       <= '0;
      r_col_a       <= '0;
      r_col_b       <= '0;
      sel_ready     <= 1'b0;
      sel_reject    <= 1'b0;
      rf_w_enable   <= 1'b0;
      rf_w_address  <= '0;
      rf_w_data     <= '0;
      rf_r_address  <= '0;
      pair_found    <= 1'b0;
      pair_miss     <= 1'b0;
      pairs_matched <= '0;
      game_done     <= 1'b0;
`ifdef CARD_MISS_COUNT_EN
      miss_count    <= '0;
`endif
    end else begin
      rf_w_enable <= 1'b0;
      sel_reject  <= 1'b0;
      pair_found  <= 1'b0;
      pair_miss   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            rf_r_address <= sel_index;
            sel_ready    <= 1'b0;
            r_state      <= ST_CHK1;
          end else begin
            sel_ready <= 1'b1;
          end
        end

        ST_CHK1: begin
          sel_ready <= 1'b1;
          if (w_legal1) begin
            rf_w_enable  <= 1'b1;
            rf_w_address <= rf_r_address;
            rf_w_data    <= card_word(w_rd_colour, CARD_FACE_UP);
            r_idx_a      <= rf_r_address;
            r_col_a      <= w_rd_colour;
            r_state      <= ST_WAIT2;
          end else begin
            sel_reject <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        ST_WAIT2: begin
          if (w_accept) begin
            rf_r_address <= sel_index;
            sel_ready    <= 1'b0;
            r_state      <= ST_CHK2;
          end else begin
            sel_ready <= 1'b1;
          end
        end

        ST_CHK2: begin
          if (w_legal2) begin
            rf_w_enable  <= 1'b1;
            rf_w_address <= rf_r_address;
            rf_w_data    <= card_word(w_rd_colour, CARD_FACE_UP);
            r_idx_b      <= rf_r_address;
            r_col_b      <= w_rd_colour;
            r_state      <= ST_HOLD;
          end else begin
            sel_reject <= 1'b1;
            sel_ready  <= 1'b1;
            r_state    <= ST_WAIT2;
          end
        end

        ST_HOLD: begin
          if (w_expired) begin
            rf_w_enable  <= 1'b1;
            rf_w_address <= r_idx_a;
            rf_w_data    <= card_word(r_col_a, w_res_state);
            r_state      <= ST_RES_A;
          end
        end

        ST_RES_A: begin
          rf_w_enable  <= 1'b1;
          rf_w_address <= r_idx_b;
          rf_w_data    <= card_word(r_col_b, w_res_state);
          if (w_colour_eq) begin
            pair_found    <= 1'b1;
            pairs_matched <= pairs_matched + ADDR_W'(1);
          end else begin
            pair_miss <= 1'b1;
`ifdef CARD_MISS_COUNT_EN
            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
`endif
          end
          r_state <= ST_RES_B;
        end

        ST_RES_B: begin
          // pairs_matched already holds the post-resolve count here.
          if (pairs_matched == ALL_PAIRS) begin
            game_done <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            sel_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        ST_DONE: begin
          sel_ready <= 1'b0;
          game_done <= 1'b1;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_match_ctrl.sv
// Bench for card_match_ctrl: table-driven game, hand-written latency/reset
// sequences and randomized games against a card-level reference model.
module tb_card_match_ctrl;
  import card_pkg::*;

  localparam int NC = 4;
  localparam int HC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_index = '0;
  logic        sel_ready, sel_reject, rf_w_enable;
  logic [3:0]  rf_w_address, rf_r_address, pairs_matched;
  logic [13:0] rf_w_data, rf_r_data;
  logic        pair_found, pair_miss, game_done;
`ifdef CARD_MISS_COUNT_EN
  logic [7:0]  miss_count;
`endif

  card_match_ctrl #(.N_CARDS(NC), .HOLD_CYCLES(HC)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_valid    (sel_valid),
    .sel_index    (sel_index),
    .sel_ready    (sel_ready),
    .sel_reject   (sel_reject),
    .rf_w_enable  (rf_w_enable),
    .rf_w_address (rf_w_address),
    .rf_w_data    (rf_w_data),
    .rf_r_address (rf_r_address),
    .rf_r_data    (rf_r_data),
    .pair_found   (pair_found),
    .pair_miss    (pair_miss),
    .pairs_matched(pairs_matched),
    .game_done    (game_done)
`ifdef CARD_MISS_COUNT_EN
    ,
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side register file
  logic [13:0] rf     [16];
  logic [13:0] pre_rf [16];
  logic        load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) rf[i] <= pre_rf[i];
    end else if (rf_w_enable) begin
      rf[rf_w_address] <= rf_w_data;
    end
  end

  assign rf_r_data = rf[rf_r_address];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: card states/colours, pick phase, counters
  int m_state [16];
  int m_col   [16];
  bit m_second;
  int m_a, m_pairs, m_miss;
  bit m_done;

  task automatic model_init();
    for (int i = 0; i < 16; i++) begin
      m_state[i] = 2;
      m_col[i]   = int'(pre_rf[i][13:2]);
    end
    m_second = 0; m_a = 0; m_pairs = 0; m_miss = 0; m_done = 0;
  endtask

  task automatic model_sel(input int idx, output int rej, output int nw,
                           output int fnd, output int mis);
    bit legal;
    rej = 0; nw = 0; fnd = 0; mis = 0;
    legal = (idx < NC) && (m_state[idx] == 2) && !(m_second && idx == m_a);
    if (!legal) begin
      rej = 1;
    end else if (!m_second) begin
      m_state[idx] = 1; m_a = idx; m_second = 1; nw = 1;
    end else begin
      nw = 3;
      m_second = 0;
      if (m_col[idx] == m_col[m_a]) begin
        m_state[idx] = 0; m_state[m_a] = 0; m_pairs++; fnd = 1;
        if (m_pairs == NC / 2) m_done = 1;
      end else begin
        m_state[idx] = 2; m_state[m_a] = 2; m_miss++; mis = 1;
      end
    end
  endtask

  task automatic reset_load();
    rst  = 1'b0;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for sel_ready, present one selection, then observe a fixed window.
  task automatic step(input int idx, output int rej, output int nw,
                      output int fnd, output int mis);
    bit ok = 0;
    rej = 0; nw = 0; fnd = 0; mis = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sel_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("ready_wait", 0, 1);
      rej = -1; nw = -1; fnd = -1; mis = -1;
      return;
    end
    sel_valid = 1'b1;
    sel_index = 4'(idx);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) sel_valid = 1'b0;
      rej += int'(sel_reject);
      nw  += int'(rf_w_enable);
      fnd += int'(pair_found);
      mis += int'(pair_miss);
    end
  endtask

  typedef struct {
    int idx; int rej; int nw; int fnd; int mis; int pairs; int done; int st;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int   a_rej, a_nw, a_f, a_m;
    int   e_rej, e_nw, e_f, e_m;
    int   n, bad, cnt_w, cnt_r, cnt_rdy;
    logic [11:0] c0, c1, tmp;
    logic [11:0] deck [4];

    // idx, rej, writes, found, miss, pairs, done, state of idx afterwards
    tbl[0] = '{0, 0, 1, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 3, 0, 1, 0, 0, 2};
    tbl[3] = '{5, 1, 0, 0, 0, 0, 0, 2};
    tbl[4] = '{0, 0, 1, 0, 0, 0, 0, 1};
    tbl[5] = '{2, 0, 3, 1, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{1, 0, 1, 0, 0, 1, 0, 1};
    tbl[8] = '{3, 0, 3, 1, 0, 2, 1, 0};

    for (int i = 0; i < 16; i++) pre_rf[i] = {12'h00F, 2'b10};
    pre_rf[0] = {12'hF00, 2'b10};
    pre_rf[1] = {12'h0F0, 2'b10};
    pre_rf[2] = {12'hF00, 2'b10};
    pre_rf[3] = {12'h0F0, 2'b10};

    // Reset state
    rst = 1'b0;
    #3;
    chk("rst_sel_ready", int'(sel_ready), 0);
    chk("rst_rf_r_address", int'(rf_r_address), 0);
    chk("rst_rf_w_enable", int'(rf_w_enable), 0);
    chk("rst_pairs", int'(pairs_matched), 0);
    chk("rst_game_done", int'(game_done), 0);
    reset_load();

    // Table-driven game
    for (int s = 0; s < 9; s++) begin
      step(tbl[s].idx, a_rej, a_nw, a_f, a_m);
      chk($sformatf("t%0d_reject", s), a_rej, tbl[s].rej);
      chk($sformatf("t%0d_writes", s), a_nw, tbl[s].nw);
      chk($sformatf("t%0d_found", s), a_f, tbl[s].fnd);
      chk($sformatf("t%0d_miss", s), a_m, tbl[s].mis);
      chk($sformatf("t%0d_pairs", s), int'(pairs_matched), tbl[s].pairs);
      chk($sformatf("t%0d_done", s), int'(game_done), tbl[s].done);
      chk($sformatf("t%0d_card_state", s), int'(rf[tbl[s].idx][1:0]), tbl[s].st);
    end

    // DONE ignores selections
    @(negedge clk);
    chk("done_ready_low", int'(sel_ready), 0);
    cnt_w = 0; cnt_r = 0; cnt_rdy = 0;
    sel_valid = 1'b1;
    sel_index = 4'd2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      cnt_w += int'(rf_w_enable);
      cnt_r += int'(sel_reject);
      cnt_rdy += int'(sel_ready);
    end
    sel_valid = 1'b0;
    chk("done_no_writes", cnt_w, 0);
    chk("done_no_reject", cnt_r, 0);
    chk("done_ready_stays_low", cnt_rdy, 0);
    chk("done_held", int'(game_done), 1);

    // Exact latencies
    reset_load();
    n = 0;
    while (!sel_ready && n < 20) begin @(negedge clk); n++; end
    sel_valid = 1'b1; sel_index = 4'd0;
    @(posedge clk); #1;
    sel_valid = 1'b0;
    chk("lat_r_address", int'(rf_r_address), 0);
    chk("lat_no_early_write", int'(rf_w_enable), 0);
    @(posedge clk); #1;
    chk("lat_faceup_wen", int'(rf_w_enable), 1);
    chk("lat_faceup_addr", int'(rf_w_address), 0);
    chk("lat_faceup_data", int'(rf_w_data), 14'h3C01);
    @(posedge clk); #1;
    chk("lat_wen_one_cycle", int'(rf_w_enable), 0);
    n = 0;
    while (!sel_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    sel_valid = 1'b1; sel_index = 4'd2;
    @(posedge clk); #1;
    sel_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      n++;
      if (rf_w_enable && rf_w_address == 4'd0) break;
    end
    chk("lat_resolve_a_cycles", n, HC + 1);
    chk("lat_resolve_a_data", int'(rf_w_data), 14'h3C00);
    @(posedge clk); #1;
    chk("lat_resolve_b_addr", int'(rf_w_address), 2);
    chk("lat_resolve_b_found", int'(pair_found), 1);

    // Reset in the middle of HOLD
    step(1, a_rej, a_nw, a_f, a_m);
    n = 0;
    while (!sel_ready && n < 20) begin @(negedge clk); n++; end
    sel_valid = 1'b1; sel_index = 4'd3;
    @(posedge clk); #1;
    sel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_pairs", int'(pairs_matched), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_pairs", int'(pairs_matched), 0);
    chk("mid_rst_wen", int'(rf_w_enable), 0);
    chk("mid_rst_wdata", int'(rf_w_data), 0);
    chk("mid_rst_raddr", int'(rf_r_address), 0);
    chk("mid_rst_ready", int'(sel_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt_w = 0; cnt_rdy = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cnt_w += int'(rf_w_enable);
      cnt_rdy += int'(sel_ready);
    end
    chk("post_rst_no_writes", cnt_w, 0);
    chk("post_rst_idle_ready", int'(cnt_rdy > 0), 1);
    chk("post_rst_card1_left", int'(rf[1][1:0]), 1);
    chk("post_rst_card3_left", int'(rf[3][1:0]), 1);

    // Randomized games against the model
    for (int g = 0; g < 4; g++) begin
      c0 = 12'($urandom);
      c1 = c0 ^ 12'($urandom_range(1, 12'hFFF));
      deck[0] = c0; deck[1] = c0; deck[2] = c1; deck[3] = c1;
      for (int i = 3; i > 0; i--) begin
        n = $urandom_range(0, i);
        tmp = deck[i]; deck[i] = deck[n]; deck[n] = tmp;
      end
      for (int i = 0; i < 16; i++)
        pre_rf[i] = {(i < 4) ? deck[i] : 12'($urandom), 2'b10};
      reset_load();
      model_init();
      for (int s = 0; s < 30 && !m_done; s++) begin
        n = $urandom_range(0, 5);
        model_sel(n, e_rej, e_nw, e_f, e_m);
        step(n, a_rej, a_nw, a_f, a_m);
        chk($sformatf("g%0d_s%0d_reject", g, s), a_rej, e_rej);
        chk($sformatf("g%0d_s%0d_writes", g, s), a_nw, e_nw);
        chk($sformatf("g%0d_s%0d_found", g, s), a_f, e_f);
        chk($sformatf("g%0d_s%0d_miss", g, s), a_m, e_m);
        chk($sformatf("g%0d_s%0d_pairs", g, s), int'(pairs_matched), m_pairs);
        chk($sformatf("g%0d_s%0d_done", g, s), int'(game_done), int'(m_done));
`ifdef CARD_MISS_COUNT_EN
        chk($sformatf("g%0d_s%0d_miss_count", g, s), int'(miss_count), m_miss);
`endif
        bad = 0;
        for (int i = 0; i < 16; i++)
          if (rf[i] != {12'(m_col[i]), 2'(m_state[i])}) bad++;
        chk($sformatf("g%0d_s%0d_rf_image", g, s), bad, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_match_ctrl.md
Name: card_match_ctrl

Overview:
- Game-logic writer and reader for the card-state register file.
- Accepts player card selections and flips selected face-down cards face-up.
- Holds two flipped cards visible for a fixed time, then writes them back as matched (inactive) or face-down.
- Counts found pairs and flags game completion.
- Sits between the input/cursor logic and the card register file; the drawing logic reads the same register file through its own port.

Parameters:
- N_CARDS, 16, number of cards; must be even and at most 16.
- HOLD_CYCLES, 100_000_000, clock cycles both cards stay face-up before resolve (1 s at 100 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sel_valid  input  1  player selection request.
- sel_index  input  4  selected card address.
- sel_ready  output  1  controller can accept a selection.
- sel_reject  output  1  one-cycle pulse: selection refused.
- rf_w_enable  output  1  register-file write strobe.
- rf_w_address  output  4  register-file write address.
- rf_w_data  output  14  register-file write data.
- rf_r_address  output  4  register-file read address.
- rf_r_data  input  14  register-file read data; combinational from rf_r_address.
- pair_found  output  1  one-cycle pulse on match resolve.
- pair_miss  output  1  one-cycle pulse on mismatch resolve.
- pairs_matched  output  4  count of resolved matched pairs.
- game_done  output  1  high once all pairs are matched.

Behaviour:
- Register-file word layout:
  - bits [1:0] are card state: 00 inactive/matched, 01 face-up, 10 face-down.
  - bits [13:2] are colour, r,g,b from MSB to LSB.
- Reset (rst low, asynchronous):
  - state returns to IDLE.
  - All outputs go to 0, except rf_r_address, which goes to 0 as well.
  - Counters, timer and latched first/second card are cleared.
- A selection is accepted when sel_valid && sel_ready.
- sel_ready is 1 only in IDLE and WAIT2.
- State machine:
  - IDLE: on accept, drive rf_r_address = sel_index, latch the index, go to CHK1.
  - CHK1 (1 cycle):
    - Legal card (index < N_CARDS and rf_r_data[1:0] == 10): rf_w_enable = 1, address = index, data = {colour, 01}. Latch colour A and index A. Go to WAIT2.
    - Otherwise: sel_reject pulses, no write, go back to IDLE.
  - WAIT2: on accept, drive rf_r_address = sel_index, go to CHK2.
  - CHK2 (1 cycle):
    - Rejected if index == index A, index >= N_CARDS, or state != 10. On reject, sel_reject pulses and the FSM returns to WAIT2.
    - Otherwise, write {colour, 01}, latch index B and colour B, clear the timer, go to HOLD.
  - HOLD: the timer counts to HOLD_CYCLES-1 and then goes to RES_A. Selections are not accepted in HOLD.
  - RES_A (1 cycle): write index A with {colour A, 00} if colour A == colour B, else {colour A, 10}.
  - RES_B (1 cycle):
    - Write index B in the same way.
    - On match: pair_found pulses and pairs_matched increments.
    - On mismatch: pair_miss pulses.
    - Next state is DONE if the new count equals N_CARDS/2, else IDLE.
  - DONE: game_done = 1, sel_ready = 0, no writes; stays until reset.
- rf_w_enable is high in exactly one cycle per write; at most one write per cycle.
- Latency:
  - Accept to face-up write: 1 cycle.
  - Second accept to resolve of card A: HOLD_CYCLES+1 cycles.
- Colour comparison covers all 12 colour bits; the state bits are excluded.
- Reset in HOLD or RES_A leaves register-file contents as written. The card initialiser re-deals the cards; this block does not repair them.

Optional Feature:
- Macro: CARD_MISS_COUNT_EN.
- Defined:
  - Adds output miss_count, 8 bits, reset to 0.
  - Increments on every pair_miss and saturates at 255.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package card_pkg:
  - state encodings CARD_INACTIVE = 2'b00, CARD_FACE_UP = 2'b01, CARD_FACE_DOWN = 2'b10.
  - widths CARD_W = 14, COLOUR_W = 12, ADDR_W = 4.
  - FSM state constants.
- One natural sub-module, hold_timer: start pulse, HOLD_CYCLES parameter, one-cycle expired output.

Test Plan (HOLD_CYCLES = 4, N_CARDS = 4; register file preloaded with colours 0xF00, 0x0F0, 0xF00, 0x0F0, all state 10):
- Select 0, then 2 → writes 0xF00 with state 01 at addresses 0 and 2. After 4 HOLD cycles, both written with state 00; pair_found pulses once; pairs_matched = 1.
- Select 0, then 1 → both written face-up, then written back with state 10; pair_miss pulses; pairs_matched unchanged.
- Select 0 twice → second select gets sel_reject; no write; FSM stays in WAIT2; selecting 2 then completes normally.
- Select an already-matched card (state 00), or index 5 → sel_reject pulses; no rf_w_enable.
- Match 0/2 then 1/3 → game_done = 1 after the second RES_B; later sel_valid is ignored with sel_ready = 0.
- Assert rst low mid-HOLD → all outputs go to 0 immediately and the FSM returns to IDLE.
- With CARD_MISS_COUNT_EN: three mismatches → miss_count = 3.
